// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: turns load-use, taken-branch and data-memory wait
// conditions into per-stage hold/bubble controls, plus stall statistics and a timeout flag.
module hazard_ctrl #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  id_rs_addr,
    input  logic [3:0]  id_rt_addr,
    input  logic        id_uses_rs,
    input  logic        id_uses_rt,
    input  logic        ex_mem_read,
    input  logic [3:0]  ex_rd_addr,
    input  logic        ex_WriteReg,
    input  logic        ex_branch_taken,
    input  logic        mem_req,
    input  logic        mem_ready,
    output logic        pc_stall_n,
    output logic        if_id_stall_n,
    output logic        id_ex_stall_n,
    output logic        ex_mem_stall_n,
    output logic        mem_wb_stall_n,
    output logic        if_id_flush,
    output logic        id_ex_flush,
    output logic [15:0] stall_cycles,
    output logic        mem_timeout
);

    typedef enum logic {
        ST_RUN      = 1'b0,
        ST_MEM_WAIT = 1'b1
    } state_t;

    localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [15:0] r_wait_cnt;
    logic [15:0] r_stall_cycles;
    logic        r_mem_timeout;

    logic w_mem_busy;
    logic w_lu_hit;
    logic w_freeze;
    logic w_pc_stall_n;
    logic w_if_id_stall_n;
    logic w_id_ex_stall_n;
    logic w_ex_mem_stall_n;
    logic w_mem_wb_stall_n;
    logic w_if_id_flush;
    logic w_id_ex_flush;

    assign w_mem_busy = mem_req & ~mem_ready;
    assign w_lu_hit   = ex_mem_read & ex_WriteReg & (ex_rd_addr != 4'd0) &
                        ((id_uses_rs & (id_rs_addr == ex_rd_addr)) |
                         (id_uses_rt & (id_rt_addr == ex_rd_addr)));
    assign w_freeze   = (r_state == ST_MEM_WAIT) | w_mem_busy;

    // Next-state logic for the memory-wait FSM
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_RUN: begin
                if (w_mem_busy) w_state_nxt = ST_MEM_WAIT;
                else            w_state_nxt = ST_RUN;
            end
            ST_MEM_WAIT: begin
                if (mem_ready) w_state_nxt = ST_RUN;
                else           w_state_nxt = ST_MEM_WAIT;
            end
            default: w_state_nxt = ST_RUN;
        endcase
    end

    // Stage hold/bubble decode; freeze outranks branch, branch outranks load-use
    always_comb begin
        w_pc_stall_n     = 1'b1;
        w_if_id_stall_n  = 1'b1;
        w_id_ex_stall_n  = 1'b1;
        w_ex_mem_stall_n = 1'b1;
        w_mem_wb_stall_n = 1'b1;
        w_if_id_flush    = 1'b0;
        w_id_ex_flush    = 1'b0;
        if (w_freeze) begin
            w_pc_stall_n     = 1'b0;
            w_if_id_stall_n  = 1'b0;
            w_id_ex_stall_n  = 1'b0;
            w_ex_mem_stall_n = 1'b0;
            w_mem_wb_stall_n = 1'b0;
        end else if (ex_branch_taken) begin
            w_if_id_flush = 1'b1;
            w_id_ex_flush = 1'b1;
        end else if (w_lu_hit) begin
            // One-cycle bubble; the load reaches MEM next cycle and forwards to EX
            w_pc_stall_n    = 1'b0;
            w_if_id_stall_n = 1'b0;
            w_id_ex_flush   = 1'b1;
        end else begin
            w_pc_stall_n = 1'b1;
        end
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_RUN;
        else     r_state <= w_state_nxt;
    end

    // Wait counter and sticky timeout; the FSM keeps waiting after a timeout
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wait_cnt    <= 16'd0;
            r_mem_timeout <= 1'b0;
        end else if (r_state == ST_MEM_WAIT) begin
            if (r_wait_cnt != 16'hFFFF) r_wait_cnt <= r_wait_cnt + 16'd1;
            else                        r_wait_cnt <= r_wait_cnt;
            if (r_wait_cnt >= WAIT_LAST) r_mem_timeout <= 1'b1;
            else                         r_mem_timeout <= r_mem_timeout;
        end else begin
            r_wait_cnt    <= 16'd0;
            r_mem_timeout <= r_mem_timeout;
        end
    end

    // Saturating count of PC-hold cycles
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                         r_stall_cycles <= 16'd0;
        else if (!w_pc_stall_n && r_stall_cycles != 16'hFFFF) r_stall_cycles <= r_stall_cycles + 16'd1;
        else                                             r_stall_cycles <= r_stall_cycles;
    end

    assign pc_stall_n     = w_pc_stall_n;
    assign if_id_stall_n  = w_if_id_stall_n;
    assign id_ex_stall_n  = w_id_ex_stall_n;
    assign ex_mem_stall_n = w_ex_mem_stall_n;
    assign mem_wb_stall_n = w_mem_wb_stall_n;
    assign if_id_flush    = w_if_id_flush;
    assign id_ex_flush    = w_id_ex_flush;
    assign stall_cycles   = r_stall_cycles;
    assign mem_timeout    = r_mem_timeout;

endmodule
